// File: rtl/qevent_sched.sv
// Per-channel timed codeword dispatcher: each qubit channel pops an event from its FIFO,
// waits for the timeline to reach the event time, then issues the codeword or flags it late.
module qevent_sched #(
  parameter int NCH = 7,
  parameter int TW  = 20,
  parameter int CW  = 18
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    run,
  input  logic [TW-1:0]           t_cnt,
  input  logic [NCH-1:0]          fifo_empty,
  input  logic [(TW+CW)*NCH-1:0]  fifo_rdata,
  output logic [NCH-1:0]          fifo_rd_en,
  output logic [NCH-1:0]          cw_valid,
  output logic [CW*NCH-1:0]       cw_data,
  output logic [NCH-1:0]          err_late,
  input  logic                    err_clr,
  output logic                    busy
);

  localparam int EW = TW + CW;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ARMED = 2'd2
  } state_t;

  // Modular distance to the event time; negative means the time has already passed,
  // which stays correct across the t_cnt wrap as long as events are within half a period.
  function automatic logic signed [TW-1:0] time_diff(input logic [TW-1:0] ev_time,
                                                     input logic [TW-1:0] now);
    return signed'(ev_time - now);
  endfunction

  logic [NCH-1:0] active;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    state_t                 state_q, state_d;
    logic [TW-1:0]          stg_time;
    logic [CW-1:0]          stg_cw;
    logic signed [TW-1:0]   d;
    logic                   can_fetch, hit, late, rd;
    logic                   vld_p1, err_q;
    logic [CW-1:0]          data_p1;

    assign d         = time_diff(stg_time, t_cnt);
    assign can_fetch = run & ~fifo_empty[i];
    assign hit       = (state_q == ARMED) && (d == '0);
    assign late      = (state_q == ARMED) && d[TW-1];

    always_comb begin
      state_d = state_q;
      rd      = 1'b0;
      case (state_q)
        IDLE: begin
          if (can_fetch) begin
            rd      = 1'b1;
            state_d = FETCH;
          end
        end
        FETCH: state_d = ARMED;
        ARMED: begin
          if (hit || late) begin
            // Chain straight into the next fetch so back-to-back events stay 2 cycles apart.
            if (can_fetch) begin
              rd      = 1'b1;
              state_d = FETCH;
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        state_q  <= IDLE;
        stg_time <= '0;
        stg_cw   <= '0;
        vld_p1   <= 1'b0;
        data_p1  <= '0;
        err_q    <= 1'b0;
      end else begin
        state_q <= state_d;
        if (state_q == FETCH) begin
          {stg_time, stg_cw} <= fifo_rdata[i*EW +: EW];
        end
        // Issue stage: codeword registered one cycle after the time match
        vld_p1 <= hit;
        if (hit) begin
          data_p1 <= stg_cw;
        end
        err_q <= (err_q & ~err_clr) | late;
      end
    end

    assign fifo_rd_en[i]        = reset & rd;
    assign cw_valid[i]          = vld_p1;
    assign cw_data[i*CW +: CW]  = data_p1;
    assign err_late[i]          = err_q;
    assign active[i]            = (state_q != IDLE);
  end

  assign busy = reset & ((|active) | (run & ~(&fifo_empty)));

endmodule

// File: tb/tb_qevent_sched.sv
// Bench for qevent_sched: FIFO responders, an event-level timing model feeding per-channel
// expectation queues, and a negedge monitor that checks pops, issues and late flags.
module tb_qevent_sched;

  localparam int NCH = 7;
  localparam int TW  = 20;
  localparam int CW  = 18;
  localparam int EW  = TW + CW;

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic                 run = 1'b0;
  logic                 err_clr = 1'b0;
  logic [TW-1:0]        t_cnt = '0;
  logic [NCH-1:0]       fifo_empty = '1;
  logic [EW*NCH-1:0]    fifo_rdata = '0;
  logic [NCH-1:0]       fifo_rd_en;
  logic [NCH-1:0]       cw_valid;
  logic [CW*NCH-1:0]    cw_data;
  logic [NCH-1:0]       err_late;
  logic                 busy;

  always #5 clk = ~clk;

  qevent_sched #(.NCH(NCH), .TW(TW), .CW(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .t_cnt      (t_cnt),
    .fifo_empty (fifo_empty),
    .fifo_rdata (fifo_rdata),
    .fifo_rd_en (fifo_rd_en),
    .cw_valid   (cw_valid),
    .cw_data    (cw_data),
    .err_late   (err_late),
    .err_clr    (err_clr),
    .busy       (busy)
  );

  typedef struct {
    int            cyc;
    logic [CW-1:0] cw;
  } exp_t;

  logic [EW-1:0]   fq [NCH][$];   // FIFO contents seen by the DUT
  int              pq [NCH][$];   // expected pop cycles
  exp_t            cq [NCH][$];   // expected issue cycle and codeword
  int              lq [NCH][$];   // cycle at which err_late must become visible
  int              free_c [NCH];  // earliest cycle the channel may pop its next event
  int              cyc = 0;
  int              t_base_cyc = 0;
  logic [TW-1:0]   t_base = '0;
  logic [NCH-1:0]  pop_pend = '0;
  logic [NCH-1:0]  exp_err = '0;
  logic            clr_prev = 1'b0;
  logic            chk_idle = 1'b0;
  int              n_chk = 0;
  int              n_fail = 0;

  function automatic logic [TW-1:0] t_at(input int c);
    return t_base + TW'(c - t_base_cyc);
  endfunction

  function automatic bit pending();
    for (int i = 0; i < NCH; i++)
      if (fq[i].size() || pq[i].size() || cq[i].size() || lq[i].size()) return 1'b1;
    return 1'b0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < NCH; i++) begin
      if (pop_pend[i]) begin
        if (fq[i].size() > 0) fifo_rdata[i*EW +: EW] = fq[i].pop_front();
        pop_pend[i] = 1'b0;
      end
      fifo_empty[i] = (fq[i].size() == 0);
    end
    t_cnt = t_cnt + 1'b1;
  endtask

  task automatic set_time(input logic [TW-1:0] v);
    t_cnt      = v;
    t_base     = v;
    t_base_cyc = cyc;
  endtask

  // Event-level outcome: pop when both the event and the channel are available,
  // evaluate two cycles later, then either late immediately or issue when time matches.
  task automatic push(input int ch, input logic [TW-1:0] tm, input logic [CW-1:0] cw);
    int            p, e, m;
    logic [TW-1:0] d;
    exp_t          x;
    fq[ch].push_back({tm, cw});
    fifo_empty[ch] = 1'b0;
    p = (free_c[ch] > cyc) ? free_c[ch] : cyc;
    pq[ch].push_back(p);
    e = p + 2;
    d = tm - t_at(e);
    if (d[TW-1]) begin
      lq[ch].push_back(e + 1);
      free_c[ch] = e;
    end else begin
      m = e + int'(d);
      x.cyc = m + 1;
      x.cw  = cw;
      cq[ch].push_back(x);
      free_c[ch] = m;
    end
  endtask

  task automatic flush_model();
    for (int i = 0; i < NCH; i++) begin
      fq[i].delete(); pq[i].delete(); cq[i].delete(); lq[i].delete();
      free_c[i] = 0;
    end
    fifo_empty = '1;
    pop_pend   = '0;
  endtask

  task automatic drain();
    int guard = 0;
    while (pending() && guard < 3000) begin
      tick();
      guard++;
    end
    if (pending()) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain_timeout cyc%0d: expected events still outstanding after %0d cycles", cyc, guard);
      flush_model();
    end
    repeat (3) tick();
    chk_idle = 1'b1;
    repeat (3) tick();
    chk_idle = 1'b0;
  endtask

  always @(negedge clk) begin
    logic e;
    logic set;
    if (!reset) begin
      n_chk++;
      if (fifo_rd_en != '0 || cw_valid != '0 || cw_data != '0 || err_late != '0 || busy != 1'b0) begin
        n_fail++;
        $display("FAIL reset_outputs cyc%0d got rd_en=%0h cw_valid=%0h cw_data=%0h err_late=%0h busy=%0b, required all 0",
                 cyc, fifo_rd_en, cw_valid, cw_data, err_late, busy);
      end
      exp_err  = '0;
      clr_prev = 1'b0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        e = (pq[i].size() > 0) && (pq[i][0] == cyc);
        if (fifo_rd_en[i] || e) begin
          n_chk++;
          if (fifo_rd_en[i] !== e) begin
            n_fail++;
            $display("FAIL fifo_rd_en ch%0d cyc%0d got %0b required %0b", i, cyc, fifo_rd_en[i], e);
          end
          if (e) void'(pq[i].pop_front());
        end
        if (fifo_rd_en[i]) pop_pend[i] = 1'b1;

        e = (cq[i].size() > 0) && (cq[i][0].cyc == cyc);
        if (cw_valid[i] || e) begin
          n_chk++;
          if (cw_valid[i] !== e) begin
            n_fail++;
            $display("FAIL cw_valid ch%0d cyc%0d t_cnt=%0h got %0b required %0b", i, cyc, t_cnt, cw_valid[i], e);
          end else if (cw_data[i*CW +: CW] !== cq[i][0].cw) begin
            n_fail++;
            $display("FAIL cw_data ch%0d cyc%0d got %0h required %0h", i, cyc, cw_data[i*CW +: CW], cq[i][0].cw);
          end
          if (e) void'(cq[i].pop_front());
        end

        set = (lq[i].size() > 0) && (lq[i][0] == cyc);
        if (set) void'(lq[i].pop_front());
        exp_err[i] = (exp_err[i] & ~clr_prev) | set;
        n_chk++;
        if (err_late[i] !== exp_err[i]) begin
          n_fail++;
          $display("FAIL err_late ch%0d cyc%0d got %0b required %0b", i, cyc, err_late[i], exp_err[i]);
        end
      end
      clr_prev = err_clr;
      if (chk_idle) begin
        n_chk++;
        if (busy !== 1'b0 || fifo_rd_en !== '0) begin
          n_fail++;
          $display("FAIL idle_busy cyc%0d got busy=%0b rd_en=%0h required 0/0", cyc, busy, fifo_rd_en);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < NCH; i++) free_c[i] = 0;
    repeat (3) tick();
    reset = 1'b1;
    run   = 1'b1;
    tick();

    // Single event on ch0
    set_time(20'd0);
    push(0, 20'd40, 18'h00123);
    drain();

    // Parallel channels, same and adjacent times
    set_time(20'd90);
    push(0, 20'd100, 18'h0AAAA);
    push(2, 20'd100, 18'h15555);
    push(1, 20'd101, 18'h3C3C3);
    drain();

    // Late event, clear, then late coinciding with clear
    set_time(20'd50);
    push(3, 20'd5, 18'h00077);
    repeat (5) tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    tick();
    push(3, 20'd6, 18'h00078);
    tick();
    tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    repeat (3) tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    drain();

    // Wrap of the timeline
    set_time(20'hFFFF0);
    push(1, 20'h00003, 18'h2BEEF);
    drain();

    // Back-to-back, then one that cannot make it
    set_time(20'd190);
    push(4, 20'd200, 18'h00C8);
    push(4, 20'd202, 18'h00CA);
    push(4, 20'd203, 18'h00CB);
    drain();

    // Reset while armed abandons the event
    set_time(20'd290);
    push(5, 20'd300, 18'h1F00D);
    repeat (4) tick();
    reset = 1'b0;
    flush_model();
    repeat (2) tick();
    reset = 1'b1;
    repeat (12) tick();
    drain();

    // run=0 with non-empty FIFOs: no fetch, not busy
    run = 1'b0;
    fq[6].push_back({20'd0, 18'h00001});
    fq[0].push_back({20'd0, 18'h00002});
    fifo_empty[6] = 1'b0;
    fifo_empty[0] = 1'b0;
    chk_idle = 1'b1;
    repeat (6) tick();
    chk_idle = 1'b0;
    flush_model();
    run = 1'b1;
    tick();

    // Randomized traffic, one round straddling the wrap
    for (int r = 0; r < 6; r++) begin
      set_time((r == 0) ? 20'hFFF80 : TW'($urandom));
      for (int c = 0; c < 300; c++) begin
        tick();
        err_clr = ($urandom_range(0, 15) == 0);
        if ($urandom_range(0, 2) == 0)
          push($urandom_range(0, NCH - 1), t_cnt + TW'($urandom_range(0, 50) - 8), CW'($urandom));
      end
      tick();
      err_clr = 1'b0;
      drain();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
